// File: rtl/bp_stream_arb.sv
// bp_stream_arb: round-robin arbiter granting whole locked streams from num_req_p requesters onto one stream bus.
module bp_stream_arb #(
  parameter int num_req_p = 2,
  parameter int header_width_p = 32,
  parameter int stream_data_width_p = 64,
  parameter int max_beats_p = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p*header_width_p-1:0]      req_header_i,
  input  logic [num_req_p*stream_data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [num_req_p-1:0]                     req_lock_i,
  output logic [num_req_p-1:0]                     req_ready_o,
  output logic [header_width_p-1:0]                mem_header_o,
  output logic [stream_data_width_p-1:0]           mem_data_o,
  output logic                                     mem_v_o,
  output logic                                     mem_lock_o,
  input  logic                                     mem_ready_i,
  output logic [num_req_p-1:0]                     grant_o,
  output logic                                     err_o
);
  localparam int iw = $clog2(num_req_p);
  localparam int cw = $clog2(max_beats_p+1);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state;
  logic [iw-1:0] grant_r, ptr_r, sel_idle, sel;
  logic [cw-1:0] beat_cnt;
  logic err_r, found, busy, hs;
  function automatic logic [iw-1:0] nxt(input logic [iw-1:0] x);
    return (int'(x) == num_req_p-1) ? '0 : x + 1'b1;
  endfunction
  // Search from the round-robin pointer; the first valid requester wins.
  always_comb begin
    sel_idle = '0;
    found = 1'b0;
    for (int k = 0; k < num_req_p; k++)
      if (!found && req_v_i[(int'(ptr_r)+k) % num_req_p]) begin
        sel_idle = iw'((int'(ptr_r)+k) % num_req_p);
        found = 1'b1;
      end
  end
  always_comb begin
    busy = state == BUSY;
    sel = busy ? grant_r : sel_idle;
    mem_v_o = ~reset_i & req_v_i[sel];
    mem_lock_o = req_lock_i[sel];
    mem_header_o = req_header_i[sel*header_width_p +: header_width_p];
    mem_data_o = req_data_i[sel*stream_data_width_p +: stream_data_width_p];
    grant_o = (~reset_i & (busy | found)) ? {{(num_req_p-1){1'b0}}, 1'b1} << sel : '0;
    req_ready_o = grant_o & {num_req_p{mem_ready_i}};
    err_o = err_r & ~reset_i;
    hs = mem_v_o & mem_ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      ptr_r <= '0;
      grant_r <= '0;
      beat_cnt <= '0;
      err_r <= 1'b0;
    end else begin
      if (hs && mem_lock_o && beat_cnt == cw'(max_beats_p-1)) err_r <= 1'b1;
      if (!busy) begin
        if (found) begin
          if (hs && !mem_lock_o) ptr_r <= nxt(sel_idle);
          else begin
            state <= BUSY;
            grant_r <= sel_idle;
            beat_cnt <= hs ? cw'(1) : '0;
          end
        end
      end else if (hs) begin
        if (!mem_lock_o) begin
          state <= IDLE;
          ptr_r <= nxt(grant_r);
          beat_cnt <= '0;
        end else beat_cnt <= (beat_cnt == cw'(max_beats_p)) ? beat_cnt : beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bp_stream_arb.sv
// tb_bp_stream_arb: directed scenarios plus randomized traffic checked against a stream-level reference model.
module tb_bp_stream_arb;
  localparam int N = 2, HW = 8, DW = 16, MB = 8;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [N*HW-1:0] req_header_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0] req_v_i = '0, req_lock_i = '0, req_ready_o, grant_o;
  logic [HW-1:0] mem_header_o;
  logic [DW-1:0] mem_data_o;
  logic mem_v_o, mem_lock_o, err_o;
  logic mem_ready_i = 1'b0;
  int tests = 0, fails = 0;
  int owner = -1, ptr = 0, cnt = 0;
  bit err = 0;
  always #5 clk = ~clk;
  bp_stream_arb #(.num_req_p(N), .header_width_p(HW), .stream_data_width_p(DW), .max_beats_p(MB)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_header_i(req_header_i), .req_data_i(req_data_i),
    .req_v_i(req_v_i), .req_lock_i(req_lock_i), .req_ready_o(req_ready_o),
    .mem_header_o(mem_header_o), .mem_data_o(mem_data_o), .mem_v_o(mem_v_o),
    .mem_lock_o(mem_lock_o), .mem_ready_i(mem_ready_i), .grant_o(grant_o), .err_o(err_o));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // One cycle: drive at negedge, check outputs against the model, then advance the model to the next edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk, input logic rdy, input logic rs);
    int s;
    bit any, ev, h;
    logic [N-1:0] eg;
    @(negedge clk);
    reset_i = rs; req_v_i = v; req_lock_i = lk; mem_ready_i = rdy;
    for (int i = 0; i < N; i++) begin
      req_data_i[i*DW +: DW] = DW'($urandom);
      req_header_i[i*HW +: HW] = HW'($urandom);
    end
    #1;
    any = |v;
    s = owner;
    if (owner < 0) begin
      s = ptr;
      for (int k = N-1; k >= 0; k--) if (v[(ptr+k)%N]) s = (ptr+k)%N;
    end
    ev = !rs && v[s];
    eg = (!rs && (owner >= 0 || any)) ? N'(1 << s) : '0;
    chk("mem_v", mem_v_o, ev);
    chk("grant", grant_o, eg);
    chk("ready", req_ready_o, eg & {N{rdy}});
    chk("err", err_o, !rs && err);
    if (ev) begin
      chk("data", mem_data_o, req_data_i[s*DW +: DW]);
      chk("header", mem_header_o, req_header_i[s*HW +: HW]);
      chk("lock", mem_lock_o, lk[s]);
    end
    h = ev && rdy;
    if (rs) begin
      owner = -1; ptr = 0; cnt = 0; err = 0;
    end else begin
      if (h && lk[s] && cnt == MB-1) err = 1;
      if (h && !lk[s]) begin
        owner = -1; ptr = (s+1)%N; cnt = 0;
      end else if (owner >= 0 || any) begin
        owner = s;
        if (h) cnt = (cnt < MB) ? cnt + 1 : MB;
      end
    end
  endtask
  initial begin
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b11, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, 1'b1, 1'b0);
      chk("rr_seq", grant_o, (i % 2) ? 2'b10 : 2'b01);
    end
    step(2'b10, 2'b10, 1'b1, 1'b0);
    step(2'b11, 2'b10, 1'b1, 1'b0);
    chk("busy_hold", grant_o, 2'b10);
    step(2'b11, 2'b11, 1'b1, 1'b1);
    step(2'b11, 2'b00, 1'b1, 1'b0);
    chk("post_reset", grant_o, 2'b01);
    for (int i = 0; i < 8; i++) step(2'b01, 2'b01, 1'b1, 1'b0);
    chk("err_before", err_o, 1'b0);
    step(2'b01, 2'b00, 1'b1, 1'b0);
    chk("err_set", err_o, 1'b1);
    step(2'b10, 2'b00, 1'b1, 1'b0);
    chk("err_sticky", err_o, 1'b1);
    for (int i = 0; i < 4000; i++)
      step(N'($urandom), N'({$urandom_range(0,99) < 85, $urandom_range(0,99) < 85}),
           $urandom_range(0,3) != 0, $urandom_range(0,199) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bp_stream_arb.md
BP_STREAM_ARB -- requirements
Module: bp_stream_arb

Interface
REQ-001 Parameter num_req_p, default 2, meaning: number of streaming requesters (legal range 2..4).
REQ-002 Parameter header_width_p, default bp_bedrock_xce_mem_msg_header_width_lp, meaning: bedrock memory header width.
REQ-003 Parameter stream_data_width_p, default dword_width_p, meaning: data width per beat.
REQ-004 Parameter max_beats_p, default cce_block_width_p/dword_width_p, meaning: maximum legal beats in one stream.
REQ-005 Port clk_i, input, 1: the single clock.
REQ-006 Port reset_i, input, 1: synchronous, active-high reset.
REQ-007 Port req_header_i, input, num_req_p*header_width_p: per-requester header; requester i occupies slice i.
REQ-008 Port req_data_i, input, num_req_p*stream_data_width_p: per-requester beat data.
REQ-009 Port req_v_i, input, num_req_p: per-requester beat valid.
REQ-010 Port req_lock_i, input, num_req_p: 1 = more beats follow; 0 = last or only beat.
REQ-011 Port req_ready_o, output, num_req_p: per-requester ready.
REQ-012 Ports mem_header_o / mem_data_o / mem_v_o / mem_lock_o, output, header_width_p / stream_data_width_p / 1 / 1: the shared stream bus to the downstream stream pump.
REQ-013 Port mem_ready_i, input, 1: downstream ready.
REQ-014 Port grant_o, output, num_req_p: one-hot owner of the bus; zero when mem_v_o=0 in IDLE.
REQ-015 Port err_o, output, 1: sticky stream-length violation flag.

Function
REQ-016 A beat transfers on a cycle where mem_v_o & mem_ready_i; the granted requester's req_ready_o[i] SHALL equal mem_ready_i, and every other req_ready_o bit SHALL be 0.
REQ-017 mem_header_o, mem_data_o, mem_lock_o SHALL be combinational muxes of the granted requester's inputs; mem_v_o = req_v_i[granted]; 0-cycle latency.
REQ-018 mem_v_o SHALL NOT depend combinationally on mem_ready_i.
REQ-019 States: IDLE, BUSY; state, grant_r (index), ptr_r (round-robin pointer), beat_cnt, err_r are registered.
REQ-020 IDLE: selected requester = first i with req_v_i[i]=1 searching ptr_r, ptr_r+1, ... modulo num_req_p.
REQ-021 IDLE, no valid request: mem_v_o=0, grant_o=0, state unchanged.
REQ-022 IDLE, handshake with lock=0: remain IDLE; ptr_r <= selected+1 mod num_req_p.
REQ-023 IDLE, valid but no handshake, or handshake with lock=1: go BUSY; grant_r <= selected; beat_cnt <= 1 if a beat transferred, else 0.
REQ-024 BUSY: only grant_r forwarded regardless of other valids; each handshake increments beat_cnt.
REQ-025 BUSY, handshake with lock=0: go IDLE; ptr_r <= grant_r+1 mod num_req_p; beat_cnt <= 0.
REQ-026 BUSY, granted requester deasserts req_v_i mid-stream: mem_v_o=0, grant held; no other requester served.
REQ-027 ptr_r SHALL update only on a last-beat handshake (lock=0).
REQ-028 A handshake with lock=1 when beat_cnt = max_beats_p-1 SHALL set err_r; err_r clears only on reset; arbitration continues unchanged.
REQ-029 beat_cnt width clog2(max_beats_p+1), saturates at max_beats_p.

Reset
REQ-030 While reset_i=1: mem_v_o=0, req_ready_o=0, grant_o=0, err_o=0.
REQ-031 After reset: state=IDLE, ptr_r=0, grant_r=0, beat_cnt=0, err_r=0.
REQ-032 Reset asserted mid-stream SHALL abandon the stream; the next cycle after deassertion starts in IDLE with ptr_r=0.

Verification
REQ-033 num_req_p=2, both req_v_i=1, lock=0, mem_ready_i=1 for 4 cycles -> grant_o sequence 01,10,01,10.
REQ-034 Req0 sends 4 beats (lock 1,1,1,0), req1 valid throughout -> 4 consecutive req0 beats, req1 granted on 5th cycle, req_ready_o[1]=0 for first 4 cycles.
REQ-035 Req1 valid alone, mem_ready_i=0 for 3 cycles, then req0 asserts -> grant stays 10, mem_data_o stable until handshake.
REQ-036 max_beats_p=8, req0 sends 9 beats with lock=1 on beats 1..8 -> err_o=1 from cycle after beat 8, remains 1 until reset.
REQ-037 Reset pulse after 2 beats of a 4-beat req1 stream, both requesting -> first post-reset grant = req0 (ptr_r=0).
REQ-038 Req0 deasserts req_v_i for 2 cycles mid-stream while req1 valid -> mem_v_o=0, grant_o=01, req1 not served until req0 last beat.
